// File: rtl/imm_rotate_encoder_if.sv
// Request/result bundle for the rotated-immediate encoder.
// The master drives start/value; the slave returns the status and the result.
interface imm_rotate_encoder_if;
  logic        start;
  logic [31:0] value;
  logic        busy;
  logic        done;
  logic        valid;
  logic [7:0]  imm8;
  logic [3:0]  rot;

  modport master (
    output start, value,
    input  busy, done, valid, imm8, rot
  );

  modport slave (
    input  start, value,
    output busy, done, valid, imm8, rot
  );
endinterface

// File: rtl/imm_rotate_encoder.sv
// Iterative search for the ARM rotated-immediate form of a 32-bit constant.
// Tests one even rotation per clock and reports the smallest matching rot.
module imm_rotate_encoder (
  input  logic                 clk,
  input  logic                 rst,
  imm_rotate_encoder_if.slave  bus
);

  typedef enum logic [1:0] {StIdle, StSearch, StDone} state_e;

  state_e      state_q, state_d;
  logic [3:0]  r_q, r_d;
  logic [31:0] value_q, value_d;
  logic        valid_q, valid_d;
  logic [7:0]  imm8_q, imm8_d;
  logic [3:0]  rot_q, rot_d;

  logic [4:0]  sh;
  logic [31:0] cand;

  // Rotate left by 2*r; the right-shift term vanishes when the amount is 0.
  assign sh   = {r_q, 1'b0};
  assign cand = (value_q << sh) | (value_q >> (6'd32 - {1'b0, sh}));

  always_comb begin
    state_d = state_q;
    r_d     = r_q;
    value_d = value_q;
    valid_d = valid_q;
    imm8_d  = imm8_q;
    rot_d   = rot_q;
    unique case (state_q)
      StIdle, StDone: begin
        if (bus.start) begin
          value_d = bus.value;
          r_d     = 4'd0;
          state_d = StSearch;
        end else begin
          state_d = StIdle;
        end
      end
      StSearch: begin
        if (cand[31:8] == 24'd0) begin
          valid_d = 1'b1;
          imm8_d  = cand[7:0];
          rot_d   = r_q;
          state_d = StDone;
        end else if (r_q == 4'd15) begin
          valid_d = 1'b0;
          imm8_d  = 8'd0;
          rot_d   = 4'd0;
          state_d = StDone;
        end else begin
          r_d = r_q + 4'd1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      r_q     <= 4'd0;
      value_q <= 32'd0;
      valid_q <= 1'b0;
      imm8_q  <= 8'd0;
      rot_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      r_q     <= r_d;
      value_q <= value_d;
      valid_q <= valid_d;
      imm8_q  <= imm8_d;
      rot_q   <= rot_d;
    end
  end

  assign bus.busy  = (state_q == StSearch);
  assign bus.done  = (state_q == StDone);
  assign bus.valid = valid_q;
  assign bus.imm8  = imm8_q;
  assign bus.rot   = rot_q;

endmodule
